// File: rtl/calc_pkg.sv
// Shared opcode, state and token-kind encodings for the calculator front-end.
// calc_sequencer imports this package.
package calc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADD1 = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;
  localparam logic [3:0] OP_LAND = 4'd6;
  localparam logic [3:0] OP_LOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_LT   = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_GT   = 4'd11;

  localparam logic [2:0] ST_A    = 3'd0;
  localparam logic [2:0] ST_OP   = 3'd1;
  localparam logic [2:0] ST_B    = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  typedef enum logic [2:0] {
    S_A    = ST_A,
    S_OP   = ST_OP,
    S_B    = ST_B,
    S_EXEC = ST_EXEC,
    S_OUT  = ST_OUT
  } state_t;

  localparam logic KIND_OPND = 1'b0;
  localparam logic KIND_OP   = 1'b1;

endpackage

// File: rtl/calc_sequencer.sv
// Token-stream front-end for the combinational calculator: operand/opcode/operand in, registered result out.
// Optional CALC_CHAIN_EN macro: each result becomes operand A of the next computation.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              OP_W       = 4,
  parameter logic [DATA_W-1:0] ERR_RESULT = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] calc_input1,
  output logic [DATA_W-1:0] calc_input2,
  output logic [OP_W-1:0]   calc_opcode,
  input  logic [DATA_W-1:0] calc_result,
  input  logic              calc_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_overflow,
  output logic              err
);

  state_t            state, state_n;
  logic [DATA_W-1:0] in1_n, in2_n, res_n;
  logic [OP_W-1:0]   op_n;
  logic              ovf_n, err_n;
  logic              chained, chained_n;
  logic              accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_A;
      calc_input1  <= '0;
      calc_input2  <= '0;
      calc_opcode  <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      err          <= 1'b0;
      chained      <= 1'b0;
    end else begin
      state        <= state_n;
      calc_input1  <= in1_n;
      calc_input2  <= in2_n;
      calc_opcode  <= op_n;
      out_result   <= res_n;
      out_overflow <= ovf_n;
      err          <= err_n;
      chained      <= chained_n;
    end
  end

  always_comb begin
    state_n   = state;
    in1_n     = calc_input1;
    in2_n     = calc_input2;
    op_n      = calc_opcode;
    res_n     = out_result;
    ovf_n     = out_overflow;
    err_n     = 1'b0;
    chained_n = 1'b0;
    in_ready  = (state == S_A) || (state == S_OP) || (state == S_B);
    out_valid = (state == S_OUT);
    accept    = in_valid && in_ready;

    case (state)
      S_A: begin
        if (accept) begin
          if (in_kind == KIND_OPND) begin
            in1_n   = in_data;
            state_n = S_OP;
          end else begin
            err_n   = 1'b1;
          end
        end
      end
      S_OP: begin
        if (!accept) begin
          chained_n = chained;
        end else if (in_kind == KIND_OP) begin
          op_n = in_data[OP_W-1:0];
          if (in_data[OP_W-1:0] == OP_NOT) begin
            in2_n   = '0;
            state_n = S_EXEC;
          end else begin
            state_n = S_B;
          end
        end else if (chained) begin
          // A fresh operand while chaining overrides the carried-over result.
          in1_n     = in_data;
          chained_n = 1'b1;
        end else begin
          err_n   = 1'b1;
          state_n = S_A;
        end
      end
      S_B: begin
        if (accept) begin
          if (in_kind == KIND_OPND) begin
            in2_n   = in_data;
            state_n = S_EXEC;
          end else begin
            err_n   = 1'b1;
            state_n = S_A;
          end
        end
      end
      S_EXEC: begin
        state_n = S_OUT;
        if (((calc_opcode == OP_DIV) || (calc_opcode == OP_MOD)) && (calc_input2 == '0)) begin
          res_n = ERR_RESULT;
          ovf_n = 1'b1;
          err_n = 1'b1;
        end else begin
          res_n = calc_result;
          ovf_n = calc_overflow;
        end
      end
      S_OUT: begin
        if (out_ready) begin
`ifdef CALC_CHAIN_EN
          in1_n     = out_result;
          chained_n = 1'b1;
          state_n   = S_OP;
`else
          state_n   = S_A;
`endif
        end
      end
      default: state_n = S_A;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural calculator beside it.
// Define CALC_CHAIN_EN to also exercise result chaining.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_kind = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] calc_input1, calc_input2;
  logic [3:0] calc_opcode;
  logic [7:0] calc_result;
  logic       calc_overflow;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       out_overflow;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_data(in_data), .calc_input1(calc_input1), .calc_input2(calc_input2),
    .calc_opcode(calc_opcode), .calc_result(calc_result), .calc_overflow(calc_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .err(err)
  );

  // Stand-in for the calculator; returns {overflow, result}.
  function automatic logic [8:0] calc_model(input logic [7:0] a, input logic [3:0] op, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    case (op)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {1'b0, a} + {1'b0, b} + 9'd1;
      4'd2:  return {(a < b), a - b};
      4'd3:  return {|p[15:8], p[7:0]};
      4'd4:  return (b == 0) ? 9'd0 : {1'b0, a / b};
      4'd5:  return (b == 0) ? 9'd0 : {1'b0, a % b};
      4'd6:  return {8'd0, (a != 0) && (b != 0)};
      4'd7:  return {8'd0, (a != 0) || (b != 0)};
      4'd8:  return {1'b0, ~a};
      4'd9:  return {8'd0, a < b};
      4'd10: return {8'd0, a == b};
      4'd11: return {8'd0, a > b};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [8:0] expect_result(input logic [7:0] a, input logic [3:0] op, input logic [7:0] b);
    if ((op == 4'd4 || op == 4'd5) && b == 8'd0) return {1'b1, 8'hFF};
    return calc_model(a, op, b);
  endfunction

  always_comb {calc_overflow, calc_result} = calc_model(calc_input1, calc_opcode, calc_input2);

  // Output monitor: compare every handshaked result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got result %0d ovf %0d, nothing expected", out_result, out_overflow);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({out_overflow, out_result} !== e) begin
          miscompares++;
          $display("FAIL sb_result: got ovf %0b res %0d, expected ovf %0b res %0d",
                   out_overflow, out_result, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic k, input logic [7:0] d);
    bit done = 0;
    in_valid = 1'b1; in_kind = k; in_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: token kind %0b data %0d not accepted, required acceptance", k, d);
    end
  endtask

  task automatic wait_out();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (out_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL out_timeout: out_valid=0, required 1");
    end
  endtask

  task automatic consume();
    wait_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({calc_input1, calc_input2, calc_opcode, out_result, out_overflow, out_valid, err} !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: in1=%0d in2=%0d op=%0d res=%0d ovf=%0b ov=%0b err=%0b rdy=%0b, required zeros and rdy=1",
               calc_input1, calc_input2, calc_opcode, out_result, out_overflow, out_valid, err, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sub();
    do_reset();
    send(KIND_OPND, 8'd10);
    send(KIND_OP, 8'd2);
    sb.push_back({1'b0, 8'd5});
    send(KIND_OPND, 8'd5);
    vectors++;
    if (out_valid !== 1'b0 || calc_input1 !== 8'd10 || calc_input2 !== 8'd5 || calc_opcode !== 4'd2) begin
      miscompares++;
      $display("FAIL sub_exec: ov=%0b in1=%0d in2=%0d op=%0d, required 0/10/5/2", out_valid, calc_input1, calc_input2, calc_opcode);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_latency: ov=%0b rdy=%0b, required 1/0", out_valid, in_ready);
    end
    consume();
  endtask

  task automatic test_div_zero();
    do_reset();
    send(KIND_OPND, 8'd10);
    send(KIND_OP, 8'd4);
    sb.push_back({1'b1, 8'hFF});
    send(KIND_OPND, 8'd0);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL div0_err_early: err=%0b, required 0", err); end
    @(posedge clk); #1;
    vectors++;
    if (err !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL div0_err_pulse: err=%0b ov=%0b, required 1/1", err, out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL div0_err_width: err=%0b, required 0", err); end
    consume();
  endtask

  task automatic test_not();
    do_reset();
    send(KIND_OPND, 8'd10);
    sb.push_back({1'b0, 8'hF5});
    send(KIND_OP, 8'd8);
    vectors++;
    if (in_ready !== 1'b0 || calc_input2 !== 8'd0) begin
      miscompares++; $display("FAIL not_unary: rdy=%0b in2=%0d, required 0/0", in_ready, calc_input2);
    end
    consume();
  endtask

  task automatic test_kind_err();
    do_reset();
    send(KIND_OP, 8'd0);
    vectors++;
    if (err !== 1'b1 || in_ready !== 1'b1 || calc_opcode !== 4'd0) begin
      miscompares++; $display("FAIL kind_err: err=%0b rdy=%0b op=%0d, required 1/1/0", err, in_ready, calc_opcode);
    end
    @(posedge clk); #1;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL kind_err_width: err=%0b, required 0", err); end
    send(KIND_OPND, 8'd200);
    send(KIND_OP, 8'd0);
    sb.push_back({1'b1, 8'd44});
    send(KIND_OPND, 8'd100);
    consume();
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    send(KIND_OPND, 8'd7);
    send(KIND_OP, 8'd3);
    sb.push_back({1'b0, 8'd21});
    send(KIND_OPND, 8'd3);
    wait_out();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 8'd21 || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL stall_hold: cyc %0d ov=%0b res=%0d rdy=%0b, required 1/21/0", i, out_valid, out_result, in_ready);
      end
    end
    consume();
    send(KIND_OPND, 8'd5);
    send(KIND_OP, 8'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if ({calc_input1, calc_input2, calc_opcode, out_result, out_overflow, out_valid, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: in1=%0d op=%0d res=%0d ov=%0b, required all 0", calc_input1, calc_opcode, out_result, out_valid);
    end
  endtask

  task automatic test_passthru();
    do_reset();
    send(KIND_OPND, 8'd9);
    send(KIND_OP, 8'd13);
    sb.push_back({1'b0, 8'd0});
    send(KIND_OPND, 8'd9);
    @(posedge clk); #1;
    vectors++;
    if (err !== 1'b0 || calc_opcode !== 4'd13) begin
      miscompares++; $display("FAIL passthru: err=%0b op=%0d, required 0/13", err, calc_opcode);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [8];
    bit drained = 0;
    ops = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      logic [3:0] op;
      a  = 8'($urandom_range(0, 255));
      b  = (i % 4 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      op = ops[$urandom_range(0, 7)];
      send(KIND_OPND, a);
      send(KIND_OP, {4'd0, op});
      sb.push_back(expect_result(a, op, b));
      send(KIND_OPND, b);
    end
    for (int i = 0; i < 20 && !drained; i++) begin
      if (sb.size() == 0) drained = 1;
      else begin @(posedge clk); #1; end
    end
    out_ready = 1'b0;
    vectors++;
    if (!drained) begin
      miscompares++; $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

`ifdef CALC_CHAIN_EN
  task automatic test_chain();
    do_reset();
    send(KIND_OPND, 8'd10);
    send(KIND_OP, 8'd0);
    sb.push_back({1'b0, 8'd15});
    send(KIND_OPND, 8'd5);
    consume();
    send(KIND_OP, 8'd0);
    sb.push_back({1'b0, 8'd16});
    send(KIND_OPND, 8'd1);
    consume();
    send(KIND_OPND, 8'd3);
    vectors++;
    if (err !== 1'b0 || calc_input1 !== 8'd3 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL chain_replace: err=%0b in1=%0d rdy=%0b, required 0/3/1", err, calc_input1, in_ready);
    end
    send(KIND_OP, 8'd2);
    sb.push_back({1'b0, 8'd2});
    send(KIND_OPND, 8'd1);
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_sub();
    test_div_zero();
    test_not();
    test_kind_err();
    test_stall_and_reset();
    test_passthru();
    test_back_to_back();
`ifdef CALC_CHAIN_EN
    test_chain();
`endif
    repeat (2) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: %0d results never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
